// File: rtl/move_seq_display.sv
// Solution playback for the 8-puzzle solver: snapshots the move list on comp and shows one move per step on four 7-seg digits.
// Latency: seg*/done registered one cycle behind the state/idx registers; step_idx is the idx register itself.
// Backpressure: none; button pulses and auto-play ticks are consumed in the cycle they occur.

module msd_debounce #(
    parameter int CYC = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic pulse
);
    localparam int CW = $clog2(CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(CYC - 1);

    logic [1:0]    sync_ff;
    logic          lvl;
    logic          lvl_q;
    logic [CW-1:0] cnt;

    // cnt counts consecutive synchronised samples that disagree with the accepted level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_ff <= '0;
            lvl     <= 1'b0;
            lvl_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_ff <= {sync_ff[0], raw};
            lvl_q   <= lvl;
            if (sync_ff[1] == lvl) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                lvl <= sync_ff[1];
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign pulse = lvl & ~lvl_q;
endmodule

module move_seq_display #(
    parameter int MAX_MOVES    = 17,
    parameter int CNT_W        = 7,
    parameter int DEBOUNCE_CYC = 50000,
    parameter int AUTO_PERIOD  = 25000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   comp,
    input  logic [CNT_W-1:0]       num_moves,
    input  logic [2*MAX_MOVES-1:0] ord,
    input  logic                   btn_next,
    input  logic                   btn_prev,
    input  logic                   auto_en,
    output logic [6:0]             seg3,
    output logic [6:0]             seg2,
    output logic [6:0]             seg1,
    output logic [6:0]             seg0,
    output logic [CNT_W-1:0]       step_idx,
    output logic                   done
);
    localparam int TW = $clog2(AUTO_PERIOD + 1);
    localparam logic [TW-1:0]    TLAST = TW'(AUTO_PERIOD - 1);
    localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_MOVES);

    localparam logic [6:0] G_U = 7'b0111110;
    localparam logic [6:0] G_P = 7'b1100111;
    localparam logic [6:0] G_D = 7'b0111101;
    localparam logic [6:0] G_O = 7'b0011101;
    localparam logic [6:0] G_R = 7'b0000101;
    localparam logic [6:0] G_I = 7'b0010000;
    localparam logic [6:0] G_L = 7'b0001110;
    localparam logic [6:0] G_E = 7'b1001111;
    localparam logic [6:0] G_N = 7'b0010101;

    typedef enum logic [1:0] {IDLE, SHOW, DONE} state_t;

    state_t                 state, state_d;
    logic [CNT_W-1:0]       idx, idx_d;
    logic [CNT_W-1:0]       snap_n, snap_n_d;
    logic [2*MAX_MOVES-1:0] snap_ord, snap_ord_d;
    logic [TW-1:0]          timer, timer_d;
    logic [CNT_W-1:0]       n_clamp;
    logic                   nxt_p, prv_p;
    logic                   nxt_only, prv_only, btn_any, auto_tick, at_last;
    logic [1:0]             mv;
    logic [27:0]            seg_d, seg_q;
    logic                   done_d, done_q;

    function automatic logic [6:0] digit(input logic [7:0] d);
        case (d)
            8'd0:    return 7'b1111110;
            8'd1:    return 7'b0110000;
            8'd2:    return 7'b1101101;
            8'd3:    return 7'b1111001;
            8'd4:    return 7'b0110011;
            8'd5:    return 7'b1011011;
            8'd6:    return 7'b1011111;
            8'd7:    return 7'b1110000;
            8'd8:    return 7'b1111111;
            8'd9:    return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    // Repeated subtraction is enough: values never exceed 99
    function automatic logic [13:0] num_glyphs(input logic [7:0] v);
        logic [7:0] tens;
        logic [7:0] r;
        tens = '0;
        r    = v;
        for (int i = 0; i < 9; i++) begin
            if (r >= 8'd10) begin
                r    = r - 8'd10;
                tens = tens + 8'd1;
            end
        end
        return {digit(tens), digit(r)};
    endfunction

    msd_debounce #(.CYC(DEBOUNCE_CYC)) u_db_next (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_next),
        .pulse (nxt_p)
    );

    msd_debounce #(.CYC(DEBOUNCE_CYC)) u_db_prev (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_prev),
        .pulse (prv_p)
    );

    assign n_clamp   = (num_moves > MAX_N) ? MAX_N : num_moves;
    assign nxt_only  = nxt_p & ~prv_p;
    assign prv_only  = prv_p & ~nxt_p;
    assign btn_any   = nxt_p | prv_p;
    assign auto_tick = auto_en && (timer == TLAST) && !btn_any;
    assign at_last   = (idx == snap_n - CNT_W'(1));

    always_comb begin
        mv = 2'b00;
        for (int k = 0; k < MAX_MOVES; k++) begin
            if (idx == CNT_W'(k)) mv = snap_ord[2*k +: 2];
        end
    end

    always_comb begin
        state_d    = state;
        idx_d      = idx;
        snap_n_d   = snap_n;
        snap_ord_d = snap_ord;
        timer_d    = '0;
        if (!comp) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            case (state)
                IDLE: begin
                    snap_ord_d = ord;
                    snap_n_d   = n_clamp;
                    idx_d      = '0;
                    state_d    = (n_clamp != '0) ? SHOW : DONE;
                end
                SHOW: begin
                    if (nxt_only || auto_tick) begin
                        if (at_last) state_d = DONE;
                        else         idx_d   = idx + CNT_W'(1);
                    end else if (prv_only && idx != '0) begin
                        idx_d = idx - CNT_W'(1);
                    end
                    // a tick or any button pulse restarts the auto-play period
                    if (auto_en && !btn_any && !auto_tick) timer_d = timer + TW'(1);
                end
                DONE: begin
                    if (prv_only && snap_n != '0) begin
                        state_d = SHOW;
                        idx_d   = snap_n - CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        seg_d  = '0;
        done_d = 1'b0;
        case (state)
            SHOW: begin
                case (mv)
                    2'b00:   seg_d[27:14] = {G_U, G_P};
                    2'b01:   seg_d[27:14] = {G_D, G_O};
                    2'b10:   seg_d[27:14] = {G_R, G_I};
                    default: seg_d[27:14] = {G_L, G_E};
                endcase
                seg_d[13:0] = num_glyphs(8'(idx) + 8'd1);
            end
            DONE: begin
                seg_d  = {G_E, G_N, num_glyphs(8'(snap_n))};
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            snap_n   <= '0;
            snap_ord <= '0;
            timer    <= '0;
            seg_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_d;
            idx      <= idx_d;
            snap_n   <= snap_n_d;
            snap_ord <= snap_ord_d;
            timer    <= timer_d;
            seg_q    <= seg_d;
            done_q   <= done_d;
        end
    end

    assign {seg3, seg2, seg1, seg0} = seg_q;
    assign done     = done_q;
    assign step_idx = idx;
endmodule
